// File: rtl/serial_sub_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
// The master issues operations; the slave (serial_sub) returns the difference and flags.
interface serial_sub_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] resta;
    logic         prestamo;
    logic         desbordamiento;

    modport master (
        output start, a, b,
        input  busy, done, resta, prestamo, desbordamiento
    );

    modport slave (
        input  start, a, b,
        output busy, done, resta, prestamo, desbordamiento
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor: a - b, one bit per clock LSB first, with a registered borrow.
// Result and flags are registered and change only on entry to DONE.
module serial_sub #(
    parameter int unsigned N = 8
) (
    input logic       clk,
    input logic       rst_n,
    serial_sub_if.slave bus
);
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_accept;
    logic [N-1:0]   r_sa;
    logic [N-1:0]   r_sb;
    logic [N-1:0]   r_res;
    logic           r_borrow;
    logic [CW-1:0]  r_count;
    logic           r_amsb;
    logic           r_bmsb;
    logic [N-1:0]   r_resta;
    logic           r_prestamo;
    logic           r_desb;
    logic           w_d;
    logic           w_borrow_nxt;
    logic           w_last;

    assign w_d          = r_sa[0] ^ r_sb[0] ^ r_borrow;
    assign w_borrow_nxt = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_borrow);
    assign w_last       = (r_count == CW'(N - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = StRun;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa       <= '0;
            r_sb       <= '0;
            r_res      <= '0;
            r_borrow   <= 1'b0;
            r_count    <= '0;
            r_amsb     <= 1'b0;
            r_bmsb     <= 1'b0;
            r_resta    <= '0;
            r_prestamo <= 1'b0;
            r_desb     <= 1'b0;
        end else if (w_accept) begin
            r_sa     <= bus.a;
            r_sb     <= bus.b;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_amsb   <= bus.a[N-1];
            r_bmsb   <= bus.b[N-1];
        end else if (r_state == StRun) begin
            r_sa     <= {1'b0, r_sa[N-1:1]};
            r_sb     <= {1'b0, r_sb[N-1:1]};
            r_res    <= {w_d, r_res[N-1:1]};
            r_borrow <= w_borrow_nxt;
            r_count  <= r_count + CW'(1);
            // Final bit: publish result; w_d is the result MSB.
            if (w_last) begin
                r_resta    <= {w_d, r_res[N-1:1]};
                r_prestamo <= w_borrow_nxt;
                r_desb     <= (r_amsb != r_bmsb) && (w_d != r_amsb);
            end
        end
    end

    assign bus.busy           = (r_state == StRun);
    assign bus.done           = (r_state == StDone);
    assign bus.resta          = r_resta;
    assign bus.prestamo       = r_prestamo;
    assign bus.desbordamiento = r_desb;
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: arithmetic reference model checked every cycle,
// plus directed literal cases, held-start, mid-run reset and a random sweep.
module tb_serial_sub;
    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass = 0;

    serial_sub_if #(.N(N)) bus ();

    serial_sub #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: cycles-remaining counter and plain arithmetic on captured operands.
    int         m_cnt = 0;
    logic [7:0] m_ca = 8'h00;
    logic [7:0] m_cb = 8'h00;
    logic [7:0] m_resta = 8'h00;
    logic       m_prest = 1'b0;
    logic       m_ovf = 1'b0;
    int         m_dones = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_resta <= 8'h00;
            m_prest <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (m_cnt <= 1 && bus.start) begin
            m_ca  <= bus.a;
            m_cb  <= bus.b;
            m_cnt <= N + 1;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                m_resta <= m_ca - m_cb;
                m_prest <= (m_ca < m_cb);
                m_ovf   <= (m_ca[7] != m_cb[7]) && (((m_ca - m_cb) >> 7) & 1) != m_ca[7];
                m_dones <= m_dones + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_cnt >= 2));
        chk("done", 32'(bus.done), 32'(m_cnt == 1));
        chk("resta", 32'(bus.resta), 32'(m_resta));
        chk("prestamo", 32'(bus.prestamo), 32'(m_prest));
        chk("desbordamiento", 32'(bus.desbordamiento), 32'(m_ovf));
    end

    task automatic op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [7:0] er,
                      input logic ep, input logic eo);
        int lat;
        bit seen;
        bus.start = 1'b1;
        bus.a = ta;
        bus.b = tb_v;
        @(posedge clk);
        #2 bus.start = 1'b0;
        lat = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            lat++;
            #1 if (bus.done) seen = 1;
        end
        chk("latency", 32'(lat), 32'd9);
        chk("op_resta", 32'(bus.resta), 32'(er));
        chk("op_prestamo", 32'(bus.prestamo), 32'(ep));
        chk("op_desbordamiento", 32'(bus.desbordamiento), 32'(eo));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_resta"}, 32'(bus.resta), 32'd0);
        chk({tag, "_prestamo"}, 32'(bus.prestamo), 32'd0);
        chk({tag, "_desb"}, 32'(bus.desbordamiento), 32'd0);
    endtask

    function automatic logic [7:0] pick();
        logic [7:0] v;
        case ($urandom % 6)
            0: v = 8'h00;
            1: v = 8'h7F;
            2: v = 8'h80;
            3: v = 8'hFF;
            default: v = 8'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int ndone;
        int target;
        int cyc;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        #1 rst_n = 1'b1;

        op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        @(posedge clk);
        #2;

        // Start held high with changing operands: one done per accept, period N+1.
        ndone = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 27; i++) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            @(posedge clk);
            #1 if (bus.done) ndone++;
            #1;
        end
        bus.start = 1'b0;
        chk("held_start_dones", 32'(ndone), 32'd3);
        repeat (12) @(posedge clk);
        #2;

        // Reset mid-run at bit 4.
        bus.start = 1'b1;
        bus.a = 8'hAA;
        bus.b = 8'h55;
        @(posedge clk);
        #2 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrun_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        op(8'hAA, 8'h55, 8'h55, 1'b0, 1'b1);

        // Random sweep of at least 1000 operations, back-to-back and with gaps.
        target = m_dones + 1000;
        cyc = 0;
        while (m_dones < target && cyc < 20000) begin
            @(posedge clk);
            #2;
            bus.start = (($urandom % 4) != 0);
            bus.a = pick();
            bus.b = pick();
            cyc++;
        end
        bus.start = 1'b0;
        chk("sweep_ops", 32'(m_dones >= target), 32'd1);
        repeat (12) @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
